// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch/issue controller.
//   fetch_state_t : controller FSM state encoding
//   PC_BITS, INSTR_BITS, TARGET_BITS, CNT_BITS : default widths
package fetch_pkg;

    localparam int unsigned PC_BITS     = 12;
    localparam int unsigned INSTR_BITS  = 9;
    localparam int unsigned TARGET_BITS = 8;
    localparam int unsigned CNT_BITS    = 16;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ISSUE,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch/issue controller sitting between the program counter and the decoder.
// Presents the PC to a synchronous instruction memory, captures the returned
// word, holds it valid until the decoder accepts it, then tells the program
// counter to advance (next_ins) or branch backward (jump_flag/target).
//
// Ports:
//   clock, reset_n      : clock (rising edge), asynchronous active-low reset
//   start               : program start pulse (shared with the program counter)
//   pc, done            : current PC and done flag from the program counter
//   imem_addr/imem_rdata: instruction memory read port (data one cycle later)
//   instr, instr_pc     : captured instruction and its PC
//   instr_valid         : instr/instr_pc valid for the decoder
//   dec_ready           : decoder accepts the instruction this cycle
//   br_taken, br_target : decoder branch result for the accepted instruction
//   next_ins, jump_flag, target : handshake back to the program counter
//   busy                : fetch in progress (ADDR/DATA/ISSUE)
//   instr_count         : saturating count of instructions issued since start
module instr_fetch #(
    parameter int unsigned PC_BITS     = fetch_pkg::PC_BITS,
    parameter int unsigned INSTR_BITS  = fetch_pkg::INSTR_BITS,
    parameter int unsigned TARGET_BITS = fetch_pkg::TARGET_BITS,
    parameter int unsigned CNT_BITS    = fetch_pkg::CNT_BITS
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [PC_BITS-1:0]     pc,
    input  logic                   done,
    output logic [PC_BITS-1:0]     imem_addr,
    input  logic [INSTR_BITS-1:0]  imem_rdata,
    output logic [INSTR_BITS-1:0]  instr,
    output logic [PC_BITS-1:0]     instr_pc,
    output logic                   instr_valid,
    input  logic                   dec_ready,
    input  logic                   br_taken,
    input  logic [TARGET_BITS-1:0] br_target,
    output logic                   next_ins,
    output logic                   jump_flag,
    output logic [TARGET_BITS-1:0] target,
    output logic                   busy,
    output logic [CNT_BITS-1:0]    instr_count
);

    import fetch_pkg::*;

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    fetch_state_t              state_q, state_d;
    logic [INSTR_BITS-1:0]     instr_q, instr_d;
    logic [PC_BITS-1:0]        instr_pc_q, instr_pc_d;
    logic                      instr_valid_q, instr_valid_d;
    logic [CNT_BITS-1:0]       instr_count_q, instr_count_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        instr_count_d = instr_count_q;

        // start restarts the program from any state; the PC loads its
        // starting address on the same edge, so ADDR sees the new PC.
        if (start) begin
            state_d       = ADDR;
            instr_valid_d = 1'b0;
            instr_count_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: state_d = done ? HALT : DATA;
                DATA: begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc;
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
                ISSUE: begin
                    if (dec_ready) begin
                        instr_valid_d = 1'b0;
                        if (instr_count_q != '1) begin
                            instr_count_d = instr_count_q + CNT_ONE;
                        end
                        state_d = ADDR;
                    end
                end
                HALT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_addr = pc;
        next_ins  = (state_q == ISSUE) && dec_ready && !start;
        jump_flag = next_ins && br_taken;
        target    = jump_flag ? br_target : '0;
        busy      = (state_q == ADDR) || (state_q == DATA) || (state_q == ISSUE);
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign instr_count = instr_count_q;

endmodule
